// File: rtl/pe_ctrl_pkg.sv
// Shared types and encodings for the integer-ME PE array schedule controller.
// Optional build macro used by the controller: PE_CTRL_STALL_EN.
package pe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        COARSE = 1'b0,
        FINE   = 1'b1
    } mode_t;

    localparam int COARSE_PASSES = 2;
    localparam int FINE_PASSES   = 4;

    // Coarse-mode abs_control: MSB selects CB pair, LSB selects accumulate.
    localparam logic [1:0] ABS_P12_SHIFT = 2'd0;
    localparam logic [1:0] ABS_P12_ACC   = 2'd1;
    localparam logic [1:0] ABS_P34_SHIFT = 2'd2;
    localparam logic [1:0] ABS_P34_ACC   = 2'd3;

endpackage

// File: rtl/pe_row_decode.sv
// Combinational row-pattern decoder: (mode, pass, row) -> PE array control bits.
module pe_row_decode
    import pe_ctrl_pkg::*;
#(
    parameter int ROW_W     = 7,
    parameter int PRELOAD   = 8,
    parameter int ALT_END   = 34,
    parameter int FINE_FILL = 4
) (
    input  logic             fine_mode,
    input  logic [1:0]       pass,
    input  logic [ROW_W-1:0] row,
    output logic             cb_select,
    output logic [1:0]       abs_control,
    output logic             change_ref,
    output logic             ref_input_control
);

    localparam logic [ROW_W-1:0] PRELOAD_ROW = ROW_W'(PRELOAD);
    localparam logic [ROW_W-1:0] ALT_END_ROW = ROW_W'(ALT_END);
    localparam logic [ROW_W-1:0] FILL_ROW    = ROW_W'(FINE_FILL);

    logic acc_bit;
    logic coarse_cr;

    always_comb begin
        acc_bit   = 1'b1;
        coarse_cr = 1'b1;
        if (row < PRELOAD_ROW) begin
            acc_bit   = 1'b0;
            coarse_cr = 1'b1;
        end else if (row < ALT_END_ROW) begin
            // Even rows accumulate, odd rows shift in the next reference row.
            acc_bit   = ~row[0];
            coarse_cr = row[0];
        end
    end

    always_comb begin
        cb_select         = 1'b0;
        abs_control       = ABS_P12_SHIFT;
        change_ref        = 1'b1;
        ref_input_control = 1'b1;
        if (fine_mode) begin
            cb_select         = 1'b0;
            abs_control       = pass;
            change_ref        = 1'b1;
            ref_input_control = (row < FILL_ROW);
        end else begin
            cb_select         = ~pass[0];
            if (pass[0]) begin
                abs_control = acc_bit ? ABS_P34_ACC : ABS_P34_SHIFT;
            end else begin
                abs_control = acc_bit ? ABS_P12_ACC : ABS_P12_SHIFT;
            end
            change_ref        = coarse_cr;
            ref_input_control = 1'b1;
        end
    end

endmodule

// File: rtl/pe_array_sched_ctrl.sv
// Schedule controller: loads the CU, then sweeps search columns in coarse/fine modes.
// Optional macro PE_CTRL_STALL_EN adds ref_valid to stall the sweep.
module pe_array_sched_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int LOAD_CYCLES = 64,
    parameter int SR_COLS     = 24,
    parameter int FINE_LO     = 8,
    parameter int FINE_HI     = 15,
    parameter int COARSE_ROWS = 38,
    parameter int PRELOAD     = 8,
    parameter int ALT_END     = 34,
    parameter int FINE_ROWS   = 21,
    parameter int FINE_FILL   = 4,
    parameter int ROW_W       = 7,
    parameter int COL_W       = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
`ifdef PE_CTRL_STALL_EN
    input  logic             ref_valid,
`endif
    output logic             in_curr_enable,
    output logic             cb_select,
    output logic [1:0]       abs_control,
    output logic             change_ref,
    output logic             ref_input_control,
    output logic             step_valid,
    output logic [COL_W-1:0] search_col,
    output logic [ROW_W-1:0] search_row,
    output logic             busy,
    output logic             done
);

    localparam int LOAD_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(LOAD_CYCLES - 1);
    localparam logic [LOAD_W-1:0] LOAD_HALF = LOAD_W'(LOAD_CYCLES / 2);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(SR_COLS - 1);
    localparam logic [COL_W-1:0]  COL_FLO   = COL_W'(FINE_LO);
    localparam logic [COL_W-1:0]  COL_FHI   = COL_W'(FINE_HI);
    localparam logic [ROW_W-1:0]  CROW_LAST = ROW_W'(COARSE_ROWS - 1);
    localparam logic [ROW_W-1:0]  FROW_LAST = ROW_W'(FINE_ROWS - 1);
    localparam logic [1:0]        CPASS_LAST = 2'(COARSE_PASSES - 1);
    localparam logic [1:0]        FPASS_LAST = 2'(FINE_PASSES - 1);

    state_t            state_q, state_d;
    logic [LOAD_W-1:0] load_cnt_q, load_cnt_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [1:0]        pass_q, pass_d;
    logic [ROW_W-1:0]  row_q, row_d;

    logic             in_curr_enable_q, in_curr_enable_d;
    logic             cb_select_q, cb_select_d;
    logic [1:0]       abs_control_q, abs_control_d;
    logic             change_ref_q, change_ref_d;
    logic             ref_input_control_q, ref_input_control_d;
    logic             step_valid_q, step_valid_d;
    logic [COL_W-1:0] search_col_q, search_col_d;
    logic [ROW_W-1:0] search_row_q, search_row_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic adv_ok;
`ifdef PE_CTRL_STALL_EN
    assign adv_ok = ref_valid;
`else
    assign adv_ok = 1'b1;
`endif

    mode_t      mode;
    logic       dec_cb;
    logic [1:0] dec_abs;
    logic       dec_cr;
    logic       dec_ric;
    logic [ROW_W-1:0] row_last;
    logic [1:0]       pass_last;

    assign mode      = (col_q < COL_FLO || col_q > COL_FHI) ? COARSE : FINE;
    assign row_last  = (mode == FINE) ? FROW_LAST : CROW_LAST;
    assign pass_last = (mode == FINE) ? FPASS_LAST : CPASS_LAST;

    pe_row_decode #(
        .ROW_W     (ROW_W),
        .PRELOAD   (PRELOAD),
        .ALT_END   (ALT_END),
        .FINE_FILL (FINE_FILL)
    ) u_row_decode (
        .fine_mode         (mode == FINE),
        .pass              (pass_q),
        .row               (row_q),
        .cb_select         (dec_cb),
        .abs_control       (dec_abs),
        .change_ref        (dec_cr),
        .ref_input_control (dec_ric)
    );

    always_comb begin
        state_d             = state_q;
        load_cnt_d          = load_cnt_q;
        col_d               = col_q;
        pass_d              = pass_q;
        row_d               = row_q;
        in_curr_enable_d    = 1'b0;
        cb_select_d         = 1'b1;
        abs_control_d       = 2'd0;
        change_ref_d        = 1'b0;
        ref_input_control_d = 1'b0;
        step_valid_d        = 1'b0;
        search_col_d        = '0;
        search_row_d        = '0;
        busy_d              = 1'b0;
        done_d              = 1'b0;

        if (abort) begin
            state_d    = IDLE;
            load_cnt_d = '0;
            col_d      = '0;
            pass_d     = '0;
            row_d      = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d    = LOAD;
                        load_cnt_d = '0;
                    end
                end
                LOAD: begin
                    in_curr_enable_d = 1'b1;
                    busy_d           = 1'b1;
                    cb_select_d      = (load_cnt_q < LOAD_HALF);
                    if (load_cnt_q == LOAD_LAST) begin
                        state_d    = SCAN;
                        load_cnt_d = '0;
                        col_d      = '0;
                        pass_d     = '0;
                        row_d      = '0;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
                SCAN: begin
                    busy_d = 1'b1;
                    if (adv_ok) begin
                        step_valid_d        = 1'b1;
                        search_col_d        = col_q;
                        search_row_d        = row_q;
                        cb_select_d         = dec_cb;
                        abs_control_d       = dec_abs;
                        change_ref_d        = dec_cr;
                        ref_input_control_d = dec_ric;
                        if (row_q != row_last) begin
                            row_d = row_q + 1'b1;
                        end else begin
                            row_d = '0;
                            if (pass_q != pass_last) begin
                                pass_d = pass_q + 1'b1;
                            end else begin
                                pass_d = '0;
                                if (col_q == COL_LAST) begin
                                    col_d   = '0;
                                    state_d = DONE;
                                end else begin
                                    col_d = col_q + 1'b1;
                                end
                            end
                        end
                    end else begin
                        // Stalled: keep the array pointed at the last step.
                        cb_select_d   = cb_select_q;
                        abs_control_d = abs_control_q;
                        search_col_d  = search_col_q;
                        search_row_d  = search_row_q;
                    end
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= IDLE;
            load_cnt_q          <= '0;
            col_q               <= '0;
            pass_q              <= '0;
            row_q               <= '0;
            in_curr_enable_q    <= 1'b0;
            cb_select_q         <= 1'b1;
            abs_control_q       <= 2'd0;
            change_ref_q        <= 1'b0;
            ref_input_control_q <= 1'b0;
            step_valid_q        <= 1'b0;
            search_col_q        <= '0;
            search_row_q        <= '0;
            busy_q              <= 1'b0;
            done_q              <= 1'b0;
        end else begin
            state_q             <= state_d;
            load_cnt_q          <= load_cnt_d;
            col_q               <= col_d;
            pass_q              <= pass_d;
            row_q               <= row_d;
            in_curr_enable_q    <= in_curr_enable_d;
            cb_select_q         <= cb_select_d;
            abs_control_q       <= abs_control_d;
            change_ref_q        <= change_ref_d;
            ref_input_control_q <= ref_input_control_d;
            step_valid_q        <= step_valid_d;
            search_col_q        <= search_col_d;
            search_row_q        <= search_row_d;
            busy_q              <= busy_d;
            done_q              <= done_d;
        end
    end

    assign in_curr_enable    = in_curr_enable_q;
    assign cb_select         = cb_select_q;
    assign abs_control       = abs_control_q;
    assign change_ref        = change_ref_q;
    assign ref_input_control = ref_input_control_q;
    assign step_valid        = step_valid_q;
    assign search_col        = search_col_q;
    assign search_row        = search_row_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: tb/tb_pe_array_sched_ctrl.sv
// Self-checking bench for pe_array_sched_ctrl against a step-list model of the schedule.
module tb_pe_array_sched_ctrl;

    localparam int LOAD_CYCLES = 64;
    localparam int SR_COLS     = 24;
    localparam int FINE_LO     = 8;
    localparam int FINE_HI     = 15;
    localparam int COARSE_ROWS = 38;
    localparam int PRELOAD     = 8;
    localparam int ALT_END     = 34;
    localparam int FINE_ROWS   = 21;
    localparam int FINE_FILL   = 4;
    localparam int ROW_W       = 7;
    localparam int COL_W       = 5;
    localparam int STEPS       = 1888;
    localparam int BUSY_CYCLES = 1952;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
`ifdef PE_CTRL_STALL_EN
    logic             ref_valid;
`endif
    logic             in_curr_enable;
    logic             cb_select;
    logic [1:0]       abs_control;
    logic             change_ref;
    logic             ref_input_control;
    logic             step_valid;
    logic [COL_W-1:0] search_col;
    logic [ROW_W-1:0] search_row;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    pe_array_sched_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .abort             (abort),
`ifdef PE_CTRL_STALL_EN
        .ref_valid         (ref_valid),
`endif
        .in_curr_enable    (in_curr_enable),
        .cb_select         (cb_select),
        .abs_control       (abs_control),
        .change_ref        (change_ref),
        .ref_input_control (ref_input_control),
        .step_valid        (step_valid),
        .search_col        (search_col),
        .search_row        (search_row),
        .busy              (busy),
        .done              (done)
    );

    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
        logic             cb;
        logic [1:0]       abs_c;
        logic             cr;
        logic             ric;
    } step_t;

    step_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int load_seen, busy_cycles, step_cnt, done_cnt, icen_cnt;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic step_t mk(input int col, input int row, input int cb,
                                 input int abs_c, input int cr, input int ric);
        step_t s;
        s.col   = COL_W'(col);
        s.row   = ROW_W'(row);
        s.cb    = 1'(cb);
        s.abs_c = 2'(abs_c);
        s.cr    = 1'(cr);
        s.ric   = 1'(ric);
        return s;
    endfunction

    // Expected controls of one search step, straight from the row-pattern rules.
    function automatic step_t model_step(input int col, input int pass, input int row);
        int a;
        int cr;
        if (col < FINE_LO || col > FINE_HI) begin
            if (row < PRELOAD) begin a = 0; cr = 1; end
            else if (row < ALT_END) begin a = (row % 2 == 0) ? 1 : 0; cr = row % 2; end
            else begin a = 1; cr = 1; end
            return mk(col, row, (pass == 0) ? 1 : 0, 2 * pass + a, cr, 1);
        end
        return mk(col, row, 0, pass, 1, (row < FINE_FILL) ? 1 : 0);
    endfunction

    task automatic fill_model();
        exp_q.delete();
        for (int c = 0; c < SR_COLS; c++) begin
            int np;
            int nr;
            np = (c < FINE_LO || c > FINE_HI) ? 2 : 4;
            nr = (c < FINE_LO || c > FINE_HI) ? COARSE_ROWS : FINE_ROWS;
            for (int p = 0; p < np; p++)
                for (int r = 0; r < nr; r++)
                    exp_q.push_back(model_step(c, p, r));
        end
    endtask

    task automatic reset_stats();
        load_seen   = 0;
        busy_cycles = 0;
        step_cnt    = 0;
        done_cnt    = 0;
        icen_cnt    = 0;
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cycles++;
            if (done) begin
                done_cnt++;
                chk("done_busy_low", int'(busy), 0);
            end
            if (in_curr_enable) begin
                chk("load_cb_select", int'(cb_select), (load_seen < LOAD_CYCLES / 2) ? 1 : 0);
                chk("load_no_step", int'(step_valid), 0);
                load_seen++;
                icen_cnt++;
            end
            if (step_valid) begin
                step_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_step", 1, 0);
                end else begin
                    step_t e;
                    step_t a;
                    e = exp_q.pop_front();
                    a = mk(int'(search_col), int'(search_row), int'(cb_select),
                           int'(abs_control), int'(change_ref), int'(ref_input_control));
                    chk("step", int'(a), int'(e));
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_step_valid"}, int'(step_valid), 0);
        chk({tag, "_icen"}, int'(in_curr_enable), 0);
        chk({tag, "_cb_select"}, int'(cb_select), 1);
        chk({tag, "_abs"}, int'(abs_control), 0);
        chk({tag, "_change_ref"}, int'(change_ref), 0);
        chk({tag, "_ric"}, int'(ref_input_control), 0);
        chk({tag, "_row"}, int'(search_row), 0);
        chk({tag, "_col"}, int'(search_col), 0);
    endtask

    task automatic check_run(input string tag, input int exp_busy);
        chk({tag, "_busy_cycles"}, busy_cycles, exp_busy);
        chk({tag, "_steps"}, step_cnt, STEPS);
        chk({tag, "_load_cycles"}, icen_cnt, LOAD_CYCLES);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_model_left"}, exp_q.size(), 0);
    endtask

    task automatic run_full(input string tag);
        reset_stats();
        fill_model();
        pulse_start();
        wait_done();
        @(negedge clk);
        check_run(tag, BUSY_CYCLES);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
`ifdef PE_CTRL_STALL_EN
        ref_valid = 1'b1;
`endif
        reset_stats();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");

        // Hand-computed pins on the model itself.
        fill_model();
        chk("model_step_count", exp_q.size(), STEPS);
        chk("pin_c0_p0_r7",  int'(model_step(0, 0, 7)),  int'(mk(0, 7, 1, 0, 1, 1)));
        chk("pin_c0_p0_r8",  int'(model_step(0, 0, 8)),  int'(mk(0, 8, 1, 1, 0, 1)));
        chk("pin_c0_p1_r9",  int'(model_step(0, 1, 9)),  int'(mk(0, 9, 0, 2, 1, 1)));
        chk("pin_c0_p1_r35", int'(model_step(0, 1, 35)), int'(mk(0, 35, 0, 3, 1, 1)));
        chk("pin_c8_p2_r3",  int'(model_step(8, 2, 3)),  int'(mk(8, 3, 0, 2, 1, 1)));
        chk("pin_c8_p3_r4",  int'(model_step(8, 3, 4)),  int'(mk(8, 4, 0, 3, 1, 0)));
        chk("pin_c16_p0_r34", int'(model_step(16, 0, 34)), int'(mk(16, 34, 1, 1, 1, 1)));

        rst_n = 1'b1;
        @(negedge clk);
        $display("INFO txn: reset released");

        run_full("full_run");
        $display("INFO txn: full CU busy=%0d steps=%0d", busy_cycles, step_cnt);

        // Abort at column 10, pass 2; then a clean rerun.
        reset_stats();
        fill_model();
        pulse_start();
        n = 0;
        while (!(step_valid && search_col == 10 && abs_control == 2) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_point_reached", (n < 4000) ? 1 : 0, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle_outputs("after_abort");
        exp_q.delete();
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_stays_idle", int'(busy), 0);
        $display("INFO txn: abort at col 10 pass 2");
        run_full("rerun");
        $display("INFO txn: rerun busy=%0d", busy_cycles);

        // start held high for the whole run; start+abort together in IDLE.
        reset_stats();
        fill_model();
        start = 1'b1;
        wait_done();
        abort = 1'b1;
        @(negedge clk);
        check_run("start_held", BUSY_CYCLES);
        for (int i = 0; i < 3; i++) begin
            chk("start_abort_busy", int'(busy), 0);
            chk("start_abort_icen", int'(in_curr_enable), 0);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_start_abort", int'(busy), 0);
        $display("INFO txn: start held, start+abort idle");

`ifdef PE_CTRL_STALL_EN
        // Five-cycle reference stall at column 3, row 20.
        reset_stats();
        fill_model();
        pulse_start();
        n = 0;
        while (!(step_valid && search_col == 3 && search_row == 20 && cb_select) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("stall_point_reached", (n < 4000) ? 1 : 0, 1);
        ref_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_step_valid", int'(step_valid), 0);
            chk("stall_row_hold", int'(search_row), 20);
            chk("stall_col_hold", int'(search_col), 3);
            chk("stall_change_ref", int'(change_ref), 0);
            chk("stall_ric", int'(ref_input_control), 0);
            chk("stall_busy", int'(busy), 1);
        end
        ref_valid = 1'b1;
        wait_done();
        @(negedge clk);
        check_run("stall_run", BUSY_CYCLES + 5);
        $display("INFO txn: stall run busy=%0d", busy_cycles);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
